// File: rtl/fifo_ctrl.sv
// fifo_ctrl: synchronous FIFO controller for the dual-port Memoria array.
// Port A of the memory is write-only and follows the write pointer. Port B is
// read-only and follows the read pointer. This block owns occupancy, status
// and sticky error flags. Memoria registers its read data, so a word popped
// in cycle N shows on data_out with valid_out=1 in cycle N+1.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   push, data_in       producer write request and write data
//   pop                 consumer read request
//   data_out, valid_out read data (pass-through of mem_data_b) and its valid
//   full, empty         occupancy is 2**AW / 0
//   almost_full         count >= AF_THR
//   almost_empty        count <= AE_THR
//   count               occupancy, 0 .. 2**AW
//   overflow, underflow sticky rejected-push / rejected-pop flags
//   mem_addr_a, mem_rw_a, mem_data_a   Memoria port A (write)
//   mem_addr_b, mem_rw_b, mem_data_b   Memoria port B (read)
module fifo_ctrl #(
    parameter int AW     = 3,
    parameter int DW     = 4,
    parameter int AF_THR = 6,
    parameter int AE_THR = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] data_in,
    input  logic          pop,
    output logic [DW-1:0] data_out,
    output logic          valid_out,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow,
    output logic [AW-1:0] mem_addr_a,
    output logic          mem_rw_a,
    output logic [DW-1:0] mem_data_a,
    output logic [AW-1:0] mem_addr_b,
    output logic          mem_rw_b,
    input  logic [DW-1:0] mem_data_b
);

    localparam int DEPTH = 2 ** AW;

    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0] CNT_LAST = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0] AF_LIM   = (AW + 1)'(AF_THR);
    localparam logic [AW:0] AE_LIM   = (AW + 1)'(AE_THR);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_PARTIAL = 2'd1,
        S_FULL    = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_r;
    logic          push_ok;
    logic          pop_ok;

    // Stage p0: acceptance decided against the registered state.
    assign full    = (state == S_FULL);
    assign empty   = (state == S_EMPTY);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    assign almost_full  = (count_r >= AF_LIM);
    assign almost_empty = (count_r <= AE_LIM);
    assign count        = count_r;

    // Write port: a write strobe never reaches the array while in reset.
    assign mem_addr_a = wr_ptr;
    assign mem_data_a = data_in;
    assign mem_rw_a   = push_ok & ~reset;
    assign mem_addr_b = rd_ptr;
    assign mem_rw_b   = 1'b0;

    // Stage p1: Memoria's registered read word, qualified by valid_out.
    assign data_out = mem_data_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_r   <= '0;
            state     <= S_EMPTY;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);

            case ({push_ok, pop_ok})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase

            // A one-deep FIFO has no PARTIAL occupancy, so it toggles
            // straight between EMPTY and FULL.
            case (state)
                S_EMPTY: begin
                    if (push_ok) state <= (DEPTH == 1) ? S_FULL : S_PARTIAL;
                end
                S_PARTIAL: begin
                    if (pop_ok && !push_ok && count_r == CNT_ONE)
                        state <= S_EMPTY;
                    else if (push_ok && !pop_ok && count_r == CNT_LAST)
                        state <= S_FULL;
                end
                S_FULL: begin
                    if (pop_ok) state <= (DEPTH == 1) ? S_EMPTY : S_PARTIAL;
                end
                default: state <= S_EMPTY;
            endcase

            valid_out <= pop_ok;
            if (push && full)  overflow  <= 1'b1;
            if (pop  && empty) underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: two instances (default thresholds and AF_THR=7/AE_THR=1)
// share stimulus; a queue-based reference model predicts every output.
module tb_fifo_ctrl;

    localparam int AW = 3;
    localparam int DW = 4;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [DW-1:0] data_in = '0;

    logic [DW-1:0] data_out, mem_data_a, mem_data_b;
    logic          valid_out, full, empty, almost_full, almost_empty;
    logic          overflow, underflow, mem_rw_a, mem_rw_b;
    logic [AW:0]   count;
    logic [AW-1:0] mem_addr_a, mem_addr_b;

    logic [DW-1:0] data_out2, mem_data_a2;
    logic [DW-1:0] mem_data_b2 = '0;
    logic          valid_out2, full2, empty2, almost_full2, almost_empty2;
    logic          overflow2, underflow2, mem_rw_a2, mem_rw_b2;
    logic [AW:0]   count2;
    logic [AW-1:0] mem_addr_a2, mem_addr_b2;

    always #5 clk = ~clk;

    fifo_ctrl #(.AW(AW), .DW(DW), .AF_THR(6), .AE_THR(2)) dut (
        .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
        .data_out(data_out), .valid_out(valid_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow),
        .mem_addr_a(mem_addr_a), .mem_rw_a(mem_rw_a), .mem_data_a(mem_data_a),
        .mem_addr_b(mem_addr_b), .mem_rw_b(mem_rw_b), .mem_data_b(mem_data_b)
    );

    fifo_ctrl #(.AW(AW), .DW(DW), .AF_THR(7), .AE_THR(1)) dut2 (
        .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
        .data_out(data_out2), .valid_out(valid_out2), .full(full2), .empty(empty2),
        .almost_full(almost_full2), .almost_empty(almost_empty2), .count(count2),
        .overflow(overflow2), .underflow(underflow2),
        .mem_addr_a(mem_addr_a2), .mem_rw_a(mem_rw_a2), .mem_data_a(mem_data_a2),
        .mem_addr_b(mem_addr_b2), .mem_rw_b(mem_rw_b2), .mem_data_b(mem_data_b2)
    );

    // Memoria stand-in: write on port A, registered read on port B.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_rw_a) mem[mem_addr_a] <= mem_data_a;
        mem_data_b <= mem[mem_addr_b];
    end

    // Reference model state.
    int unsigned q[$];
    int  wp, rp;
    bit  m_ovf, m_udf, m_vld;
    int  m_data;
    int  n_chk = 0;
    int  n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        chk("count",        32'(count),        32'(sz));
        chk("empty",        32'(empty),        32'(sz == 0));
        chk("full",         32'(full),         32'(sz == DEPTH));
        chk("almost_full",  32'(almost_full),  32'(sz >= 6));
        chk("almost_empty", 32'(almost_empty), 32'(sz <= 2));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_udf));
        chk("valid_out",    32'(valid_out),    32'(m_vld));
        if (m_vld) chk("data_out", 32'(data_out), 32'(m_data));
        chk("wr_addr",      32'(mem_addr_a),   32'(wp));
        chk("rd_addr",      32'(mem_addr_b),   32'(rp));
        chk("rw_b",         32'(mem_rw_b),     32'(0));
        chk("count2",       32'(count2),       32'(sz));
        chk("almost_full2", 32'(almost_full2), 32'(sz >= 7));
        chk("almost_empty2",32'(almost_empty2),32'(sz <= 1));
    endtask

    // One clock of stimulus: drive after the falling edge, predict, check after rising edge.
    task automatic step(input bit p, input int d, input bit po);
        bit pok, pook, fl, em;
        @(negedge clk);
        push = p; pop = po; data_in = DW'(d);
        fl = (q.size() == DEPTH);
        em = (q.size() == 0);
        pok = p && !fl;
        pook = po && !em;
        #1;
        chk("rw_a", 32'(mem_rw_a), 32'(pok));
        if (p && fl)  m_ovf = 1'b1;
        if (po && em) m_udf = 1'b1;
        m_vld = pook;
        if (pook) begin
            m_data = int'(q.pop_front());
            rp = (rp + 1) % DEPTH;
        end
        if (pok) begin
            q.push_back(d & 32'hF);
            wp = (wp + 1) % DEPTH;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset(input bit p, input bit po);
        @(negedge clk);
        reset = 1'b1; push = p; pop = po; data_in = 4'hC;
        #1;
        chk("rw_a_in_reset", 32'(mem_rw_a), 32'(0));
        @(posedge clk);
        #1;
        q.delete();
        wp = 0; rp = 0; m_ovf = 0; m_udf = 0; m_vld = 0; m_data = 0;
        check_all();
        @(negedge clk);
        reset = 1'b0; push = 1'b0; pop = 1'b0;
    endtask

    initial begin
        do_reset(1'b0, 1'b0);

        // 1: push three words, pop three, one idle cycle to see the last read.
        for (int i = 1; i <= 3; i++) step(1, i, 0);
        for (int i = 0; i < 3; i++)  step(0, 0, 1);
        step(0, 0, 0);

        // 2: fill, overflow attempt with 0xF, drain.
        for (int i = 0; i < 8; i++) step(1, i, 0);
        step(1, 15, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1);
        step(0, 0, 0);

        // 3: underflow, then push+pop while empty, then read it back.
        step(0, 0, 1);
        step(1, 10, 1);
        step(0, 0, 1);
        step(0, 0, 0);

        // 4: hold count at 4 with 20 simultaneous push+pop cycles.
        for (int i = 0; i < 4; i++)  step(1, 8 + i, 0);
        for (int i = 0; i < 20; i++) step(1, i & 15, 1);
        for (int i = 0; i < 4; i++)  step(0, 0, 1);
        step(0, 0, 0);

        // 5: reset mid-stream with a read in flight and a push/pop pending.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1, 3 + i, 0);
        step(0, 0, 1);
        do_reset(1'b1, 1'b1);
        step(0, 0, 0);

        // 6: full walk 0..8..0 for both threshold sets.
        for (int i = 0; i < 8; i++) step(1, 15 - i, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1);
        step(0, 0, 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else if (i < 200) step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            else              step(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Synchronous FIFO controller that sits directly upstream of the dual-port Memoria block and drives its address, data and control pins.
- Port A of the memory is used only for writes and is driven by the write pointer.
- Port B of the memory is used only for reads and is driven by the read pointer.
- The block owns all occupancy tracking, status flags and error flags. Memoria remains the storage array and is instantiated alongside it at the same AW/DW.

Parameters:
- AW, 3: memory address width; FIFO depth is 2**AW (default 8).
- DW, 4: data word width.
- AF_THR, 6: almost_full asserts when count >= AF_THR.
- AE_THR, 2: almost_empty asserts when count <= AE_THR.

Ports:
- clk  input  1  single clock; every register updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- push  input  1  write request from the producer.
- data_in  input  DW  write data, sampled in any cycle where push is accepted.
- pop  input  1  read request from the consumer.
- data_out  output  DW  read data; a combinational pass-through of mem_data_b.
- valid_out  output  1  data_out carries the word popped in the previous cycle.
- full  output  1  FIFO holds 2**AW words.
- empty  output  1  FIFO holds 0 words.
- almost_full  output  1  count >= AF_THR.
- almost_empty  output  1  count <= AE_THR.
- count  output  AW+1  current occupancy, 0 to 2**AW.
- overflow  output  1  sticky flag: a push was rejected because the FIFO was full.
- underflow  output  1  sticky flag: a pop was rejected because the FIFO was empty.
- mem_addr_a  output  AW  to AddrA; equals wr_ptr.
- mem_rw_a  output  1  to rwA; 1 means write.
- mem_data_a  output  DW  to DataInA; equals data_in.
- mem_addr_b  output  AW  to AdrrB; equals rd_ptr.
- mem_rw_b  output  1  to rwB; tied to 0 (read only).
- mem_data_b  input  DW  from DataOutB.

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - wr_ptr=0, rd_ptr=0, count=0, state=EMPTY.
  - valid_out=0, overflow=0, underflow=0.
  - Resulting flags: empty=1, full=0, almost_empty=1, almost_full=0.
  - While reset is high, mem_rw_a is forced to 0.
  - Reset in mid-operation discards all contents. A read already in flight does not raise valid_out in the following cycle.
- Acceptance (combinational, evaluated against the registered state):
  - push_ok = push & ~full.
  - pop_ok = pop & ~empty.
  - mem_rw_a = push_ok & ~reset.
- Pointers:
  - wr_ptr increments on push_ok; rd_ptr increments on pop_ok.
  - Both are AW bits wide and wrap from 2**AW-1 to 0 with no special handling.
- Count:
  - push_ok only: count+1.
  - pop_ok only: count-1.
  - both, or neither: count unchanged.
- State machine (states EMPTY, PARTIAL, FULL); flags decode from the state register:
  - EMPTY -> PARTIAL on push_ok (pop is never accepted in EMPTY). With depth 1, EMPTY -> FULL instead.
  - PARTIAL -> EMPTY on pop_ok & ~push_ok when count==1.
  - PARTIAL -> FULL on push_ok & ~pop_ok when count==2**AW-1.
  - FULL -> PARTIAL on pop_ok (push is never accepted in FULL).
  - Any other combination: hold the current state.
- Read latency:
  - When pop_ok occurs in cycle N, mem_addr_b=rd_ptr is presented in cycle N.
  - Memoria registers the word, so valid_out=1 in cycle N+1 with data_out = that word.
  - Back-to-back pops stream one word per cycle.
- Simultaneous push and pop:
  - In PARTIAL, both are accepted. The addresses differ (wr_ptr != rd_ptr whenever 0 < count < depth), so Memoria never sees a same-address read/write collision.
  - In EMPTY, only the push is accepted and underflow is set.
  - In FULL, only the pop is accepted and overflow is set.
- Errors:
  - overflow sets on push & full; underflow sets on pop & empty.
  - Both flags stay set until reset. A rejected request changes no pointer and no memory contents.
- Threshold flags are combinational compares on the registered count, so they change in the cycle after the access that moved count.

Test Plan:
1. Reset, then push 0x1,0x2,0x3 on consecutive cycles, then pop 3 times -> valid_out high for 3 cycles, each one cycle after its pop, with data_out=0x1,0x2,0x3; empty=1 afterwards and count=0.
2. Push 8 words 0x0..0x7 -> full=1, count=8, almost_full=1 from count=6. A 9th push with data 0xF -> overflow=1, count stays 8. Draining the FIFO returns 0x0..0x7 with no 0xF.
3. Pop while empty -> underflow=1, valid_out stays 0, rd_ptr unchanged. Then push+pop in the same cycle while empty -> count=1, and the word is read back correctly.
4. Hold count at 4 and drive push+pop every cycle for 20 cycles with data incrementing from 0x0 -> count stays 4, pointers wrap past 7, and the output sequence matches the input order.
5. Fill to 5 words, assert reset for one edge mid-stream with a pop pending -> the cycle after reset: count=0, empty=1, valid_out=0, overflow=0, underflow=0, and mem_rw_a is 0 during the reset cycle.
6. Set AF_THR=7, AE_THR=1 and walk count from 0 to 8 and back to 0 -> almost_empty is 1 only at count<=1 and almost_full is 1 only at count>=7, each updating one cycle after the access.
